conf_loader: RTL and testbench

CONF_LOADER -- requirements
Module: conf_loader

---
 rtl/conf_loader.sv | 73 +++++++
 tb/tb_conf_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/conf_loader.sv
// conf_loader: unpacks header+payload packets into configuration register writes.
module conf_loader #(
  parameter int CONF_SIZE = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [31:0] s_data,
  output logic        s_ready,
  input  logic        abort,
  input  logic        clear_err,
  output logic        wr_en_ext,
  output logic [31:0] wr_addr_ext,
  output logic [31:0] wr_data_ext,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, DATA, DONE} state_t;
  state_t      state;
  logic [15:0] base, index, remaining;
  logic [31:0] addr;
  logic        xfer, in_range;
  assign s_ready  = state != DONE;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  assign xfer     = s_valid && s_ready;
  // widened before the add so base+index never wraps past 16 bits
  assign addr     = 32'(base) + 32'(index);
  assign in_range = addr < 32'(CONF_SIZE);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      base        <= '0;
      index       <= '0;
      remaining   <= '0;
      wr_en_ext   <= 1'b0;
      wr_addr_ext <= '0;
      wr_data_ext <= '0;
      err         <= 1'b0;
    end else begin
      wr_en_ext <= 1'b0;
      if (clear_err) err <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        index     <= '0;
        remaining <= '0;
      end else if (state == IDLE) begin
        if (xfer) begin
          base      <= s_data[31:16];
          remaining <= s_data[15:0];
          index     <= '0;
          state     <= s_data[15:0] == 16'd0 ? DONE : DATA;
        end
      end else if (state == DATA) begin
        if (xfer) begin
          if (in_range) begin
            wr_en_ext   <= 1'b1;
            wr_addr_ext <= addr;
            wr_data_ext <= s_data;
          end else begin
            err <= 1'b1;
          end
          index     <= index + 16'd1;
          remaining <= remaining - 16'd1;
          if (remaining == 16'd1) state <= DONE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_conf_loader.sv
// tb_conf_loader: directed scenario tests for conf_loader with hand-computed expectations.
module tb_conf_loader;
  logic        clk = 1'b0, reset = 1'b1, s_valid = 1'b0, abort = 1'b0, clear_err = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_ready, wr_en_ext, busy, done, err;
  logic [31:0] wr_addr_ext, wr_data_ext;
  int checks = 0, errors = 0;

  conf_loader #(.CONF_SIZE(16)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .abort(abort), .clear_err(clear_err), .wr_en_ext(wr_en_ext), .wr_addr_ext(wr_addr_ext),
    .wr_data_ext(wr_data_ext), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic cyc(input logic v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, done, err, busy, s_ready} !== {1'b0, 64'd0, 4'b0001}) begin errors++; $display("FAIL reset_outputs got en=%b a=%h d=%h done=%b err=%b busy=%b rdy=%b exp 0/0/0/0/0/0/1", wr_en_ext, wr_addr_ext, wr_data_ext, done, err, busy, s_ready); end
    @(posedge clk); #1; reset = 1'b0;
    cyc(1'b0, '0);
    checks++; if ({s_ready, busy, done} !== 3'b100) begin errors++; $display("FAIL reset_release got rdy=%b busy=%b done=%b exp 1/0/0", s_ready, busy, done); end
  endtask

  task automatic test_basic;
    cyc(1'b1, 32'h0000_0003);
    checks++; if ({busy, wr_en_ext, done} !== 3'b100) begin errors++; $display("FAIL basic_hdr got busy=%b en=%b done=%b exp 1/0/0", busy, wr_en_ext, done); end
    cyc(1'b1, 32'hA);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext} !== {1'b1, 32'd0, 32'hA}) begin errors++; $display("FAIL basic_w0 got en=%b a=%h d=%h exp 1/0/a", wr_en_ext, wr_addr_ext, wr_data_ext); end
    cyc(1'b1, 32'hB);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext} !== {1'b1, 32'd1, 32'hB}) begin errors++; $display("FAIL basic_w1 got en=%b a=%h d=%h exp 1/1/b", wr_en_ext, wr_addr_ext, wr_data_ext); end
    cyc(1'b1, 32'hC);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, done, s_ready, err} !== {1'b1, 32'd2, 32'hC, 3'b100}) begin errors++; $display("FAIL basic_w2 got en=%b a=%h d=%h done=%b rdy=%b err=%b exp 1/2/c/1/0/0", wr_en_ext, wr_addr_ext, wr_data_ext, done, s_ready, err); end
    cyc(1'b0, '0);
    checks++; if ({wr_en_ext, done, busy, s_ready} !== 4'b0001) begin errors++; $display("FAIL basic_end got en=%b done=%b busy=%b rdy=%b exp 0/0/0/1", wr_en_ext, done, busy, s_ready); end
  endtask

  task automatic test_zero_count;
    cyc(1'b1, 32'h0005_0000);
    checks++; if ({wr_en_ext, done, s_ready, busy} !== 4'b0101) begin errors++; $display("FAIL zero_done got en=%b done=%b rdy=%b busy=%b exp 0/1/0/1", wr_en_ext, done, s_ready, busy); end
    cyc(1'b1, 32'h0000_0000);
    checks++; if ({done, busy, s_ready} !== 3'b001) begin errors++; $display("FAIL zero_idle got done=%b busy=%b rdy=%b exp 0/0/1", done, busy, s_ready); end
  endtask

  task automatic test_range;
    cyc(1'b1, 32'h000E_0003);
    cyc(1'b1, 32'd1);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, err} !== {1'b1, 32'd14, 32'd1, 1'b0}) begin errors++; $display("FAIL range_w14 got en=%b a=%h d=%h err=%b exp 1/e/1/0", wr_en_ext, wr_addr_ext, wr_data_ext, err); end
    cyc(1'b1, 32'd2);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, err} !== {1'b1, 32'd15, 32'd2, 1'b0}) begin errors++; $display("FAIL range_w15 got en=%b a=%h d=%h err=%b exp 1/f/2/0", wr_en_ext, wr_addr_ext, wr_data_ext, err); end
    cyc(1'b1, 32'd3);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, err, done} !== {1'b0, 32'd15, 32'd2, 2'b11}) begin errors++; $display("FAIL range_oor got en=%b a=%h d=%h err=%b done=%b exp 0/f/2/1/1", wr_en_ext, wr_addr_ext, wr_data_ext, err, done); end
    cyc(1'b0, '0);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL range_sticky got err=%b exp 1", err); end
    clear_err = 1'b1;
    cyc(1'b0, '0);
    clear_err = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL range_clear got err=%b exp 0", err); end
  endtask

  task automatic test_set_wins;
    cyc(1'b1, 32'h0010_0001);
    clear_err = 1'b1;
    cyc(1'b1, 32'd7);
    clear_err = 1'b0;
    checks++; if ({err, wr_en_ext, done} !== 3'b101) begin errors++; $display("FAIL setwins got err=%b en=%b done=%b exp 1/0/1", err, wr_en_ext, done); end
    clear_err = 1'b1;
    cyc(1'b0, '0);
    clear_err = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL setwins_clear got err=%b exp 0", err); end
  endtask

  task automatic test_stall;
    cyc(1'b1, 32'h0002_0002);
    cyc(1'b1, 32'h11);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext} !== {1'b1, 32'd2, 32'h11}) begin errors++; $display("FAIL stall_w2 got en=%b a=%h d=%h exp 1/2/11", wr_en_ext, wr_addr_ext, wr_data_ext); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 32'hDEAD);
      checks++; if ({wr_en_ext, busy, done} !== 3'b010) begin errors++; $display("FAIL stall_gap%0d got en=%b busy=%b done=%b exp 0/1/0", i, wr_en_ext, busy, done); end
    end
    cyc(1'b1, 32'h22);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, busy, done} !== {1'b1, 32'd3, 32'h22, 2'b11}) begin errors++; $display("FAIL stall_w3 got en=%b a=%h d=%h busy=%b done=%b exp 1/3/22/1/1", wr_en_ext, wr_addr_ext, wr_data_ext, busy, done); end
    cyc(1'b0, '0);
    checks++; if ({wr_en_ext, busy} !== 2'b00) begin errors++; $display("FAIL stall_end got en=%b busy=%b exp 0/0", wr_en_ext, busy); end
  endtask

  task automatic test_abort;
    cyc(1'b1, 32'h0000_0004);
    cyc(1'b1, 32'h1);
    cyc(1'b1, 32'h2);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext} !== {1'b1, 32'd1, 32'h2}) begin errors++; $display("FAIL abort_w1 got en=%b a=%h d=%h exp 1/1/2", wr_en_ext, wr_addr_ext, wr_data_ext); end
    abort = 1'b1;
    cyc(1'b1, 32'h3);
    abort = 1'b0;
    checks++; if ({wr_en_ext, busy, done, s_ready} !== 4'b0001) begin errors++; $display("FAIL abort_idle got en=%b busy=%b done=%b rdy=%b exp 0/0/0/1", wr_en_ext, busy, done, s_ready); end
    cyc(1'b1, 32'h0003_0001);
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL abort_rehdr got busy=%b done=%b exp 1/0", busy, done); end
    cyc(1'b1, 32'h99);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, done} !== {1'b1, 32'd3, 32'h99, 1'b1}) begin errors++; $display("FAIL abort_next got en=%b a=%h d=%h done=%b exp 1/3/99/1", wr_en_ext, wr_addr_ext, wr_data_ext, done); end
    cyc(1'b0, '0);
  endtask

  task automatic test_reset_mid;
    cyc(1'b1, 32'h0000_0002);
    cyc(1'b1, 32'h77);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext} !== {1'b1, 32'd0, 32'h77}) begin errors++; $display("FAIL rmid_w0 got en=%b a=%h d=%h exp 1/0/77", wr_en_ext, wr_addr_ext, wr_data_ext); end
    s_data = 32'h88;
    reset = 1'b1;
    #1;
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, done, err, busy, s_ready} !== {1'b0, 64'd0, 4'b0001}) begin errors++; $display("FAIL rmid_async got en=%b a=%h d=%h done=%b err=%b busy=%b rdy=%b exp 0/0/0/0/0/0/1", wr_en_ext, wr_addr_ext, wr_data_ext, done, err, busy, s_ready); end
    @(posedge clk); #1;
    s_valid = 1'b0;
    reset = 1'b0;
    cyc(1'b0, '0);
    checks++; if ({wr_en_ext, busy, s_ready} !== 3'b001) begin errors++; $display("FAIL rmid_after got en=%b busy=%b rdy=%b exp 0/0/1", wr_en_ext, busy, s_ready); end
    cyc(1'b1, 32'h0001_0001);
    checks++; if (wr_en_ext !== 1'b0) begin errors++; $display("FAIL rmid_hdr got en=%b exp 0", wr_en_ext); end
    cyc(1'b1, 32'h55);
    checks++; if ({wr_en_ext, wr_addr_ext, wr_data_ext, done} !== {1'b1, 32'd1, 32'h55, 1'b1}) begin errors++; $display("FAIL rmid_w1 got en=%b a=%h d=%h done=%b exp 1/1/55/1", wr_en_ext, wr_addr_ext, wr_data_ext, done); end
    cyc(1'b0, '0);
    checks++; if ({wr_en_ext, busy} !== 2'b00) begin errors++; $display("FAIL rmid_end got en=%b busy=%b exp 0/0", wr_en_ext, busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_zero_count;
    test_range;
    test_set_wins;
    test_stall;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
